// File: rtl/macc_pkg.sv
// macc_pkg: op encodings shared by the MACC operand and coefficient paths
package macc_pkg;
  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SHIFT  = 2'b01;
  localparam logic [1:0] OP_ROTATE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;
endpackage

// File: rtl/shreg_nsrc_if.sv
// shreg_nsrc_if: source/op inputs and tap/status outputs of the operand shift register
interface shreg_nsrc_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int NSRC  = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [NSRC*WIDTH-1:0]  din;
  logic [NSRC-1:0]        sel;
  logic [1:0]             op;
  logic [DEPTH*WIDTH-1:0] taps;
  logic [DEPTH-1:0]       tap_vld;
  logic [WIDTH-1:0]       dout;
  logic                   dout_vld;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;
  logic                   err;
  modport master (output din, sel, op, input taps, tap_vld, dout, dout_vld, count, full, empty, err);
  modport slave  (input din, sel, op, output taps, tap_vld, dout, dout_vld, count, full, empty, err);
endinterface

// File: rtl/shreg_src_mux.sv
// shreg_src_mux: NSRC-way one-hot mux; data is zero unless sel is exactly one-hot
module shreg_src_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 2
) (
  input  logic [NSRC*WIDTH-1:0] din,
  input  logic [NSRC-1:0]       sel,
  output logic [WIDTH-1:0]      data,
  output logic                  one_hot,
  output logic                  multi_hot
);
  logic [NSRC-1:0] sel_m1;
  assign sel_m1    = sel - NSRC'(1);
  assign multi_hot = (sel & sel_m1) != '0;
  assign one_hot   = (sel != '0) && !multi_hot;
  always_comb begin
    data = '0;
    for (int k = 0; k < NSRC; k++)
      data = data | ((one_hot && sel[k]) ? din[k*WIDTH +: WIDTH] : '0);
  end
endmodule

// File: rtl/shreg_nsrc.sv
// shreg_nsrc: multi-source operand shift register with valid tracking and occupancy count
// Define SHREG_ROTATE_EN to build the wrap path; otherwise op ROTATE acts as HOLD.
module shreg_nsrc
  import macc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int NSRC  = 2
) (
  input logic         CLK,
  input logic         RST,
  shreg_nsrc_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic [WIDTH-1:0]            mux_data;
  logic                        mux_one_hot, mux_multi_hot;
  shreg_src_mux #(.WIDTH(WIDTH), .NSRC(NSRC)) u_mux (
    .din       (bus.din),
    .sel       (bus.sel),
    .data      (mux_data),
    .one_hot   (mux_one_hot),
    .multi_hot (mux_multi_hot)
  );
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (bus.op == OP_SHIFT) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      data_d[0] = mux_one_hot ? mux_data : '0;
      vld_d[0]  = mux_one_hot;
      cnt_d     = cnt_q + CW'(mux_one_hot) - CW'(vld_q[DEPTH-1]);
      err_d     = err_q | mux_multi_hot;
    end
`ifdef SHREG_ROTATE_EN
    else if (bus.op == OP_ROTATE) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      data_d[0] = data_q[DEPTH-1];
      vld_d[0]  = vld_q[DEPTH-1];
    end
`endif
    else if (bus.op == OP_CLEAR) begin
      data_d = '0;
      vld_d  = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
  assign bus.taps     = data_q;
  assign bus.tap_vld  = vld_q;
  assign bus.dout     = data_q[DEPTH-1];
  assign bus.dout_vld = vld_q[DEPTH-1];
  assign bus.count    = cnt_q;
  assign bus.full     = cnt_q == CW'(DEPTH);
  assign bus.empty    = cnt_q == '0;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_shreg_nsrc.sv
// tb_shreg_nsrc: scoreboard bench for shreg_nsrc (WIDTH=32, DEPTH=4, NSRC=2)
module tb_shreg_nsrc;
  localparam int W = 32;
  localparam int D = 4;
  localparam int N = 2;
  typedef struct {
    string        tag;
    logic [127:0] taps;
    logic [3:0]   vld;
    logic [2:0]   cnt;
    logic         err;
  } exp_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [31:0] m_data[4];
  logic [3:0]  m_vld;
  logic        m_err;
  shreg_nsrc_if #(.WIDTH(W), .DEPTH(D), .NSRC(N)) bus ();
  shreg_nsrc #(.WIDTH(W), .DEPTH(D), .NSRC(N)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] popcnt(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
  task automatic step(input logic rst_i, input logic [1:0] op_i, input logic [1:0] sel_i,
                      input logic [63:0] din_i, input string tag);
    exp_t e, o;
    logic [31:0] t;
    RST = rst_i;
    bus.op = op_i;
    bus.sel = sel_i;
    bus.din = din_i;
    if (rst_i || op_i == 2'b11) begin
      for (int i = 0; i < 4; i++) m_data[i] = '0;
      m_vld = '0;
      m_err = 1'b0;
    end else if (op_i == 2'b01) begin
      for (int i = 3; i > 0; i--) begin
        m_data[i] = m_data[i-1];
        m_vld[i]  = m_vld[i-1];
      end
      m_vld[0]  = (sel_i == 2'b01) || (sel_i == 2'b10);
      m_data[0] = (sel_i == 2'b01) ? din_i[31:0] : (sel_i == 2'b10) ? din_i[63:32] : 32'h0;
      if (sel_i == 2'b11) m_err = 1'b1;
    end
`ifdef SHREG_ROTATE_EN
    else if (op_i == 2'b10) begin
      t = m_data[3];
      e.vld[0] = m_vld[3];
      for (int i = 3; i > 0; i--) begin
        m_data[i] = m_data[i-1];
        m_vld[i]  = m_vld[i-1];
      end
      m_data[0] = t;
      m_vld[0]  = e.vld[0];
    end
`endif
    e.tag  = tag;
    e.taps = {m_data[3], m_data[2], m_data[1], m_data[0]};
    e.vld  = m_vld;
    e.cnt  = popcnt(m_vld);
    e.err  = m_err;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    o = sb.pop_front();
    check({o.tag, ".taps"}, bus.taps, o.taps);
    check({o.tag, ".vld"}, bus.tap_vld, o.vld);
    check({o.tag, ".count"}, bus.count, o.cnt);
    check({o.tag, ".err"}, bus.err, o.err);
    check({o.tag, ".dout"}, bus.dout, o.taps[127:96]);
    check({o.tag, ".dout_vld"}, bus.dout_vld, o.vld[3]);
    check({o.tag, ".full"}, bus.full, o.cnt == 3'd4);
    check({o.tag, ".empty"}, bus.empty, o.cnt == 3'd0);
    RST = 1'b0;
    bus.op = 2'b00;
    bus.sel = 2'b00;
  endtask
  initial begin
    bus.op = 2'b00;
    bus.sel = 2'b00;
    bus.din = '0;
    step(1, 2'b00, 2'b00, 64'h0, "reset");
    check("reset.empty_c", bus.empty, 1'b1);
    check("reset.dout_c", bus.dout, 32'h0);
    step(0, 2'b01, 2'b01, 64'h11, "fill1");
    step(0, 2'b01, 2'b01, 64'h22, "fill2");
    step(0, 2'b01, 2'b01, 64'h33, "fill3");
    step(0, 2'b01, 2'b01, 64'h44, "fill4");
    check("tp1.dout", bus.dout, 32'h11);
    check("tp1.tap0", bus.taps[31:0], 32'h44);
    check("tp1.count", bus.count, 3'd4);
    check("tp1.full", bus.full, 1'b1);
    step(0, 2'b01, 2'b10, {32'h55, 32'hdead}, "full_shift");
    check("tp2.dout", bus.dout, 32'h22);
    check("tp2.count", bus.count, 3'd4);
    for (int i = 0; i < 3; i++) step(0, 2'b01, 2'b00, 64'hffff_ffff_ffff_ffff, "bubble");
    check("tp2.count_b", bus.count, 3'd1);
    check("tp2.dout_b", bus.dout, 32'h55);
    check("tp2.empty_b", bus.empty, 1'b0);
    step(0, 2'b11, 2'b00, 64'h0, "clear0");
    for (int i = 1; i <= 4; i++) step(0, 2'b01, 2'b01, 64'(i), "fill_n");
    step(0, 2'b10, 2'b11, 64'h0, "rot1");
    step(0, 2'b10, 2'b01, 64'h0, "rot2");
`ifdef SHREG_ROTATE_EN
    check("tp3.dout_rot", bus.dout, 32'h3);
`else
    check("tp3.dout_hold", bus.dout, 32'h1);
`endif
    check("tp3.count", bus.count, 3'd4);
    step(0, 2'b11, 2'b00, 64'h0, "clear1");
    step(0, 2'b01, 2'b11, {32'h77, 32'h66}, "multi_sel");
    check("tp4.err", bus.err, 1'b1);
    check("tp4.vld0", bus.tap_vld[0], 1'b0);
    for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b01, {$urandom, $urandom}, "hold_err");
    check("tp4.err_hold", bus.err, 1'b1);
    step(0, 2'b11, 2'b00, 64'h0, "clear_err");
    check("tp4.err_clr", bus.err, 1'b0);
    check("tp4.taps_clr", bus.taps, 128'h0);
    step(0, 2'b01, 2'b00, 64'h0, "empty_bubble");
    check("empty_bubble.count", bus.count, 3'd0);
    step(0, 2'b01, 2'b01, 64'hA, "il_s1");
    step(0, 2'b00, 2'b01, 64'hBAD, "il_h1");
    step(0, 2'b01, 2'b10, {32'hB, 32'h0}, "il_s2");
    step(0, 2'b00, 2'b10, 64'hBAD, "il_h2");
    step(0, 2'b01, 2'b01, 64'hC, "il_s3");
    step(0, 2'b01, 2'b01, 64'hD, "il_s4");
    check("tp5.taps", bus.taps, {32'hA, 32'hB, 32'hC, 32'hD});
    check("tp5.count", bus.count, 3'd4);
    step(0, 2'b11, 2'b00, 64'h0, "clear2");
    step(0, 2'b01, 2'b01, 64'h1, "mid1");
    step(0, 2'b01, 2'b11, 64'h0, "mid_err");
    step(0, 2'b01, 2'b01, 64'h2, "mid2");
    check("tp6.pre_count", bus.count, 3'd2);
    step(1, 2'b01, 2'b01, 64'h3, "mid_rst");
    check("tp6.count", bus.count, 3'd0);
    check("tp6.empty", bus.empty, 1'b1);
    check("tp6.taps", bus.taps, 128'h0);
    check("tp6.err", bus.err, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
